// File: rtl/seg_to_hex.sv
// seg_to_hex: recovers bytes from a multiplexed two-digit 7-segment bus.
// The bus is synchronized, filtered for a settled symbol (a run of identical
// samples), decoded to a nibble and paired low-then-high into a byte.
module seg_to_hex #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg,
  output logic [7:0] hex,
  output logic       hex_valid,
  output logic       err
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } state_t;

  // Returns {valid, nibble}; any pattern outside the hex glyph set is invalid.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Run length saturates so a long-held symbol never wraps into a new strobe.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Synchronizer and sample-fill tracking. smp*_q mark whether the matching
  // sync stage holds a real sample of seg rather than the reset value, so the
  // reset contents of sync2 never count toward a run.
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic       smp1_q, smp1_d;
  logic       smp2_q, smp2_d;

  // Settle detection
  logic [7:0] run_q, run_d;
  logic       done_q, done_d;
  logic       settle;

  // Decode and reassembly
  logic [4:0] dec;
  logic       dec_ok;
  logic [3:0] dec_nib;
  logic       sel;
  state_t     state_q, state_d;
  logic [3:0] low_q, low_d;
  logic [7:0] hex_q, hex_d;
  logic       hex_valid_q, hex_valid_d;
  logic       err_q, err_d;

  // Stage 1/2: two-flop synchronizer next values.
  always_comb begin
    sync1_d = seg;
    sync2_d = sync1_q;
    smp1_d  = 1'b1;
    smp2_d  = smp1_q;
  end

  // Run counter: reload to 1 when sync2 takes a new value, else count up.
  // The strobe fires while the run equals STABLE_CYCLES and has not fired yet.
  always_comb begin
    settle = (run_q == STABLE_N) && !done_q;
    run_d  = run_q;
    done_d = done_q;
    if (smp1_q) begin
      if (!smp2_q || (sync1_q != sync2_q)) begin
        run_d  = 8'd1;
        done_d = 1'b0;
      end else begin
        run_d = sat_inc(run_q);
        if (settle) begin
          done_d = 1'b1;
        end
      end
    end
  end

  // Decode the settled symbol sitting in sync2.
  always_comb begin
    dec     = decode_seg(sync2_q[6:0]);
    dec_ok  = dec[4];
    dec_nib = dec[3:0];
    sel     = sync2_q[7];
  end

  // Pairing FSM: low digit first, then high digit completes the byte.
  // An undecodable symbol aborts the frame without touching hex.
  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    hex_d       = hex_q;
    hex_valid_d = 1'b0;
    err_d       = 1'b0;
    if (settle) begin
      if (!dec_ok) begin
        err_d   = 1'b1;
        low_d   = 4'h0;
        state_d = WAIT_LO;
      end else begin
        case (state_q)
          WAIT_LO: begin
            if (!sel) begin
              low_d   = dec_nib;
              state_d = WAIT_HI;
            end
          end
          WAIT_HI: begin
            if (sel) begin
              hex_d       = {dec_nib, low_q};
              hex_valid_d = 1'b1;
              state_d     = WAIT_LO;
            end else begin
              low_d = dec_nib;
            end
          end
          default: state_d = WAIT_LO;
        endcase
      end
    end
  end

  // All state registers; reset clears everything, including any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      smp1_q      <= 1'b0;
      smp2_q      <= 1'b0;
      run_q       <= 8'd0;
      done_q      <= 1'b0;
      state_q     <= WAIT_LO;
      low_q       <= 4'h0;
      hex_q       <= 8'h00;
      hex_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      smp1_q      <= smp1_d;
      smp2_q      <= smp2_d;
      run_q       <= run_d;
      done_q      <= done_d;
      state_q     <= state_d;
      low_q       <= low_d;
      hex_q       <= hex_d;
      hex_valid_q <= hex_valid_d;
      err_q       <= err_d;
    end
  end

  assign hex       = hex_q;
  assign hex_valid = hex_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seg_to_hex.sv
// Bench for seg_to_hex: table of bus symbols with expected byte/err events,
// scoreboarded against the DUT outputs with exact cycle timing.
module tb_seg_to_hex;

  localparam int S0 = 4;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg0, seg1;
  logic [7:0] hex0, hex1;
  logic       hv0, hv1, er0, er1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic       is_err;
    logic [7:0] hex;
  } exp_t;

  typedef struct {
    logic [7:0] seg;
    int         hold;
    int         kind;   // 0 none, 1 byte, 2 err
    logic [7:0] hex;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[$];
  logic [7:0] cur_hex0 = 8'h00;
  logic [7:0] cur_hex1 = 8'h00;
  logic [7:0] pats[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seg_to_hex #(.STABLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .seg(seg0), .hex(hex0), .hex_valid(hv0), .err(er0)
  );

  seg_to_hex #(.STABLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg1), .hex(hex1), .hex_valid(hv1), .err(er1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int inst, input logic v, input logic e, input logic [7:0] h);
    exp_t x;
    if (v || e) begin
      check($sformatf("dut%0d_not_both", inst), int'(v && e), 0);
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d_unexpected_event: valid=%0b err=%0b hex=0x%0h at cycle %0d, none expected",
                 inst, v, e, h, cyc);
      end else begin
        x = (inst == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d_evt_is_err", inst), int'(e), int'(x.is_err));
        check($sformatf("dut%0d_evt_hex", inst), int'(h), int'(x.hex));
        check($sformatf("dut%0d_evt_cycle", inst), cyc, x.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      observe(0, hv0, er0, hex0);
      observe(1, hv1, er1, hex1);
    end
  end

  function automatic vec_t mk(input logic [7:0] s, input int hold, input int kind,
                              input logic [7:0] h);
    vec_t v;
    v.seg = s; v.hold = hold; v.kind = kind; v.hex = h;
    return v;
  endfunction

  // Drive a symbol right after an edge; the capture edge is cyc+1 and an
  // output event lands STABLE_CYCLES+1 edges after that.
  task automatic apply0(input logic [7:0] v, input int hold, input int kind,
                        input logic [7:0] h);
    exp_t x;
    seg0 = v;
    x.cyc = cyc + S0 + 2;
    if (kind == 1) begin
      x.is_err = 1'b0; x.hex = h; cur_hex0 = h; q0.push_back(x);
    end else if (kind == 2) begin
      x.is_err = 1'b1; x.hex = cur_hex0; q0.push_back(x);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic apply1(input logic [7:0] v, input int hold, input int kind,
                        input logic [7:0] h);
    exp_t x;
    seg1 = v;
    x.cyc = cyc + S1 + 2;
    if (kind == 1) begin
      x.is_err = 1'b0; x.hex = h; cur_hex1 = h; q1.push_back(x);
    end else if (kind == 2) begin
      x.is_err = 1'b1; x.hex = cur_hex1; q1.push_back(x);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  initial begin
    // Stimulus table
    vecs.push_back(mk(8'h6D, 10, 0, 8'h00));
    vecs.push_back(mk(8'hF7, 10, 1, 8'hA5));
    vecs.push_back(mk(8'h6D,  8, 0, 8'h00));
    vecs.push_back(mk(8'h66,  8, 0, 8'h00));
    vecs.push_back(mk(8'h86,  8, 1, 8'h14));
    vecs.push_back(mk(8'h6D, 10, 0, 8'h00));
    vecs.push_back(mk(8'h00,  2, 0, 8'h00));
    vecs.push_back(mk(8'hF7, 10, 1, 8'hA5));
    vecs.push_back(mk(8'h6D, 10, 0, 8'h00));
    vecs.push_back(mk(8'h80, 10, 2, 8'h00));
    vecs.push_back(mk(8'hF7, 10, 0, 8'h00));
    vecs.push_back(mk(8'h3F,  8, 0, 8'h00));
    vecs.push_back(mk(8'h7E,  8, 2, 8'h00));
    vecs.push_back(mk(8'h86,  8, 0, 8'h00));
    vecs.push_back(mk(8'h3F,  3, 0, 8'h00));
    vecs.push_back(mk(8'h06,  4, 0, 8'h00));
    vecs.push_back(mk(8'h86,  4, 1, 8'h11));
    for (int d = 0; d < 16; d++) begin
      logic [3:0] lo, hi;
      lo = 4'(d);
      hi = 4'(15 - d);
      vecs.push_back(mk(pats[d], 6, 0, 8'h00));
      vecs.push_back(mk(pats[15 - d] | 8'h80, 6, 1, {hi, lo}));
    end

    // Reset state
    rst_n = 1'b0;
    seg0  = 8'hF7;
    seg1  = 8'hF7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex0", int'(hex0), 0);
    check("rst_valid0", int'(hv0), 0);
    check("rst_err0", int'(er0), 0);
    check("rst_hex1", int'(hex1), 0);
    check("rst_valid1", int'(hv1), 0);
    check("rst_err1", int'(er1), 0);
    rst_n = 1'b1;

    // High digit alone never produces output
    apply0(8'hF7, 12, 0, 8'h00);
    check("high_only_hex0", int'(hex0), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply0(vecs[i].seg, vecs[i].hold, vecs[i].kind, vecs[i].hex);
    end

    // Mid-frame asynchronous reset discards the stored low digit
    apply0(8'h6D, 10, 0, 8'h00);
    check("pre_reset_drained", q0.size(), 0);
    check("pre_reset_hex0", int'(hex0), int'(cur_hex0));
    #1;
    rst_n = 1'b0;
    seg0  = 8'hF7;
    cur_hex0 = 8'h00;
    #1;
    check("async_rst_hex0", int'(hex0), 0);
    check("async_rst_valid0", int'(hv0), 0);
    check("async_rst_err0", int'(er0), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply0(8'hF7, 12, 0, 8'h00);
    apply0(8'h6D, 10, 0, 8'h00);
    apply0(8'hF7, 10, 1, 8'hA5);

    // After reset, a held 0x00 needs a full run before it settles (as err)
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    seg0  = 8'h00;
    cur_hex0 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply0(8'h00, 10, 2, 8'h00);
    apply0(8'h6D, 10, 0, 8'h00);
    apply0(8'h80, 10, 2, 8'h00);

    // Single-sample settling: every change strobes, even a 1-cycle glitch
    apply1(8'h6D, 3, 0, 8'h00);
    apply1(8'hF7, 3, 1, 8'hA5);
    apply1(8'h6D, 3, 0, 8'h00);
    apply1(8'h00, 1, 2, 8'h00);
    apply1(8'hF7, 3, 0, 8'h00);
    apply1(8'h3F, 1, 0, 8'h00);
    apply1(8'h86, 1, 1, 8'h10);
    apply1(8'hF7, 6, 0, 8'h00);

    // Bounded drain of outstanding expectations
    for (int t = 0; t < 30 && (q0.size() != 0 || q1.size() != 0); t++) begin
      @(posedge clk);
    end
    #1;
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    check("final_hex0", int'(hex0), int'(cur_hex0));
    check("final_hex1", int'(hex1), int'(cur_hex1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_to_hex.md
SEG_TO_HEX -- requirements
Module: seg_to_hex

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive identical synchronized samples that define a settled symbol; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port seg, input, 8 bits: multiplexed display bus, asynchronous to clk; seg[7] is the digit select (0 = low nibble, 1 = high nibble) and seg[6:0] is the segment pattern.
REQ-005 The block SHALL have port hex, output, 8 bits: last reassembled byte, {high nibble, low nibble}.
REQ-006 The block SHALL have port hex_valid, output, 1 bit: one-cycle pulse when hex is updated.
REQ-007 The block SHALL have port err, output, 1 bit: one-cycle pulse when a settled symbol carries an undecodable pattern.

Function
REQ-008 seg SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-009 A run counter (8 bits, saturating) SHALL count consecutive edges on which sync2 is unchanged; a change in sync2 reloads the counter to 1.
REQ-010 A settle strobe SHALL pulse for exactly one cycle when the run length reaches STABLE_CYCLES, and SHALL NOT pulse again until sync2 changes.
REQ-011 The settled pattern SHALL decode as follows: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x77=A, 0x7C=B, 0x39=C, 0x5E=D, 0x79=E, 0x71=F; every other 7-bit value SHALL be invalid.
REQ-012 The FSM SHALL have two states: WAIT_LO and WAIT_HI.
REQ-013 In WAIT_LO, a valid settled symbol with select 0 SHALL store the low nibble and move the FSM to WAIT_HI.
REQ-014 In WAIT_LO, a valid settled symbol with select 1 SHALL be ignored; no output changes.
REQ-015 In WAIT_HI, a valid settled symbol with select 1 SHALL load hex with {decoded, stored low}, pulse hex_valid on the next cycle, and return the FSM to WAIT_LO.
REQ-016 In WAIT_HI, a valid settled symbol with select 0 SHALL overwrite the stored low nibble, and the FSM SHALL stay in WAIT_HI.
REQ-017 An invalid settled symbol in either state SHALL pulse err for one cycle, discard the stored low nibble, and move the FSM to WAIT_LO; hex SHALL be unchanged.
REQ-018 Latency: if edge k first captures the completing high-digit value into sync1, hex and hex_valid SHALL update at edge k+STABLE_CYCLES+1.
REQ-019 hex_valid and err SHALL never be asserted in the same cycle.
REQ-020 Input changes lasting fewer than STABLE_CYCLES synchronized samples SHALL produce no settle strobe and no output activity.
REQ-021 With STABLE_CYCLES=1, every sync2 change SHALL produce a settle strobe on the edge it appears.

Reset
REQ-022 While rst_n is low: hex=0x00, hex_valid=0, err=0, FSM=WAIT_LO, stored nibble=0, sync1=sync2=0x00, run counter=0.
REQ-023 Reset SHALL take effect immediately on rst_n falling, including mid-frame; a partially received frame SHALL be discarded.
REQ-024 After reset release, the first settle SHALL require a full STABLE_CYCLES run, even if seg equals 0x00.

Verification
REQ-025 Scenario: STABLE_CYCLES=4; seg=0x6D held 10 cycles, then 0xF7 held 10 cycles -> exactly one hex_valid pulse with hex=0xA5, 5 cycles after the 0xF7 capture edge; err stays 0.
REQ-026 Scenario: seg=0x6D (8 cycles), 0x66 (8 cycles), 0x86 (8 cycles) -> hex=0x14 with one hex_valid pulse; the first low nibble (5) is overwritten.
REQ-027 Scenario: seg=0x6D steady, with a 0x00 glitch lasting 2 cycles, then 0xF7 steady -> no err; hex=0xA5.
REQ-028 Scenario: seg=0x6D steady, then 0x80 steady -> err pulses once; no hex_valid; the FSM is in WAIT_LO.
REQ-029 Scenario: seg=0xF7 steady only -> no hex_valid and no err; hex stays 0x00.
REQ-030 Scenario: rst_n pulsed low after a settled 0x6D, then 0xF7 steady -> no hex_valid until a fresh low digit settles.
